// File: rtl/link_tx_scheduler_pkg.sv
// Shared types and constants for the credit-paced, transition-signalled link scheduler.
// The idle phase constants must match the downstream inport handler.
package link_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        STALL = 2'd2
    } sched_state_e;

    // Idle phase of a complementary toggle pair after reset.
    localparam logic P0 = 1'b1;
    localparam logic N0 = 1'b0;

    // A transition is counted only when both wires have moved away from the tracked phase.
    function automatic logic both_toggled(
        input logic p_wire,
        input logic n_wire,
        input logic p_reg,
        input logic n_reg
    );
        return (p_wire ^ p_reg) & (n_wire ^ n_reg);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         winner,
    output logic                       valid
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/link_tx_scheduler.sv
// Round-robin scheduler sharing one toggle-signalled link among NUM_REQ requesters,
// paced by credits returned on a second toggle pair.
module link_tx_scheduler
    import link_tx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CREDITS   = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         diff_pair_p,
    output logic                         diff_pair_n,
    input  logic                         crd_pair_p,
    input  logic                         crd_pair_n,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
    output logic                         busy,
    output logic                         crd_err
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W  = $clog2(CREDITS + 1);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              dp_q, dn_q;
    logic              crd_p_q, crd_n_q;

    logic [NUM_REQ-1:0] arb_win;
    logic               arb_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   next_ptr;
    logic               owner_req;
    logic               credit_avail;
    logic               send;
    logic               crd_ret;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_win),
        .valid  (arb_valid)
    );

    // One-hot winner to index for the owner register.
    always_comb begin
        win_idx = '0;
        sel     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel = IDX_W'(i);
            if (arb_win[sel]) begin
                win_idx = sel;
            end
        end
    end

    assign owner_req    = req[owner_q];
    assign credit_avail = (cnt_q != '0);
    assign send         = (state_q == BURST) && owner_req && credit_avail;
    assign crd_ret      = both_toggled(crd_pair_p, crd_pair_n, crd_p_q, crd_n_q);
    assign next_ptr     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        gnt = '0;
        if (send) begin
            gnt[owner_q] = 1'b1;
        end
    end

    // Credit accounting: a send and a return on the same edge cancel out.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (send && !crd_ret) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (crd_ret && !send) begin
            if (cnt_q == CNT_W'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (arb_valid && credit_avail) begin
                    state_d = BURST;
                    owner_d = win_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr;
                end else if (!credit_avail) begin
                    state_d = STALL;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr;
                    end
                end
            end
            STALL: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr;
                end else if (cnt_d != '0) begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= CNT_W'(CREDITS);
            err_q   <= 1'b0;
            dp_q    <= P0;
            dn_q    <= N0;
            crd_p_q <= P0;
            crd_n_q <= N0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (send) begin
                dp_q <= ~dp_q;
                dn_q <= ~dn_q;
            end
            if (crd_ret) begin
                crd_p_q <= ~crd_p_q;
                crd_n_q <= ~crd_n_q;
            end
        end
    end

    assign diff_pair_p = dp_q;
    assign diff_pair_n = dn_q;
    assign credit_cnt  = cnt_q;
    assign crd_err     = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Bench for link_tx_scheduler: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a behavioural link model.
module tb_link_tx_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int CREDITS   = 4;
    localparam int MAX_BURST = 8;

    logic                  clk;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    gnt;
    logic                  diff_pair_p;
    logic                  diff_pair_n;
    logic                  crd_pair_p;
    logic                  crd_pair_n;
    logic [2:0]            credit_cnt;
    logic                  busy;
    logic                  crd_err;

    int n_checks = 0;
    int n_fail   = 0;

    link_tx_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .CREDITS   (CREDITS),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .gnt         (gnt),
        .diff_pair_p (diff_pair_p),
        .diff_pair_n (diff_pair_n),
        .crd_pair_p  (crd_pair_p),
        .crd_pair_n  (crd_pair_n),
        .credit_cnt  (credit_cnt),
        .busy        (busy),
        .crd_err     (crd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the link, how many flits they have sent, credits held.
    bit m_active;
    bit m_waiting;
    int m_owner;
    int m_start;
    int m_sent;
    int m_cred;
    bit m_err;
    bit m_level;
    bit m_seen_p;
    bit m_seen_n;

    task automatic model_reset();
        m_active  = 1'b0;
        m_waiting = 1'b0;
        m_owner   = 0;
        m_start   = 0;
        m_sent    = 0;
        m_cred    = CREDITS;
        m_err     = 1'b0;
        m_level   = 1'b1;
        m_seen_p  = 1'b1;
        m_seen_n  = 1'b0;
    endtask

    function automatic logic [NUM_REQ-1:0] model_gnt();
        logic [NUM_REQ-1:0] g;
        g = '0;
        if (m_active && !m_waiting && req[m_owner] && m_cred > 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_step(input logic [NUM_REQ-1:0] g);
        bit ret;
        bit sent;
        int new_cred;
        ret      = (crd_pair_p != m_seen_p) && (crd_pair_n != m_seen_n);
        sent     = (g != '0);
        new_cred = m_cred;
        if (sent && !ret) new_cred = m_cred - 1;
        else if (ret && !sent) begin
            if (m_cred == CREDITS) m_err = 1'b1;
            else new_cred = m_cred + 1;
        end
        if (!m_active) begin
            if (req != '0 && m_cred > 0) begin
                for (int k = NUM_REQ - 1; k >= 0; k--)
                    if (req[(m_start + k) % NUM_REQ]) m_owner = (m_start + k) % NUM_REQ;
                m_active  = 1'b1;
                m_waiting = 1'b0;
                m_sent    = 0;
            end
        end else if (!req[m_owner]) begin
            m_active  = 1'b0;
            m_waiting = 1'b0;
            m_start   = (m_owner + 1) % NUM_REQ;
        end else if (m_waiting) begin
            if (new_cred > 0) m_waiting = 1'b0;
        end else if (m_cred == 0) begin
            m_waiting = 1'b1;
        end else begin
            m_sent++;
            if (m_sent == MAX_BURST) begin
                m_active = 1'b0;
                m_start  = (m_owner + 1) % NUM_REQ;
            end
        end
        m_cred = new_cred;
        if (ret) begin
            m_seen_p = ~m_seen_p;
            m_seen_n = ~m_seen_n;
        end
        if (sent) m_level = ~m_level;
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin : compare
        logic [NUM_REQ-1:0] eg;
        logic               exp_n;
        if (!reset_n) model_reset();
        eg    = model_gnt();
        exp_n = ~m_level;
        check("model gnt", gnt, eg);
        check("model busy", busy, m_active);
        check("model credit_cnt", credit_cnt, m_cred);
        check("model crd_err", crd_err, m_err);
        check("model diff_pair_p", diff_pair_p, m_level);
        check("model diff_pair_n", diff_pair_n, exp_n);
        if (reset_n) model_step(eg);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic crd_toggle();
        crd_pair_p = ~crd_pair_p;
        crd_pair_n = ~crd_pair_n;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n    = 1'b0;
        req        = '0;
        crd_pair_p = 1'b1;
        crd_pair_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin : watchdog
        #10000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int ng;
        int toggles;
        logic prev_p;
        logic [NUM_REQ-1:0] g;
        int owners[$];
        int lens[$];
        int gaps[$];
        int cur;
        int len;
        int idle;
        int o;
        bit in_run;
        bit seen;
        int ret_pct;
        int r;

        reset_n    = 1'b0;
        req        = '0;
        crd_pair_p = 1'b1;
        crd_pair_n = 1'b0;

        // Reset values held with no requests.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("reset diff_pair_p", diff_pair_p, 1);
            check("reset diff_pair_n", diff_pair_n, 0);
            check("reset credit_cnt", credit_cnt, 4);
            check("reset gnt", gnt, 0);
            check("reset busy", busy, 0);
        end

        // Single requester drains credits, stalls, then one credit buys one flit.
        do_reset();
        req     = 4'b0100;
        ng      = 0;
        toggles = 0;
        prev_p  = diff_pair_p;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gnt == 4'b0100) ng++;
            if (diff_pair_p != prev_p) toggles++;
            prev_p = diff_pair_p;
        end
        check("single gnt count", ng, 4);
        check("single toggles", toggles, 4);
        check("single credit_cnt", credit_cnt, 0);
        check("single stall gnt", gnt, 0);
        check("single stall busy", busy, 1);
        tick();
        crd_toggle();
        ng = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (gnt == 4'b0100) ng++;
        end
        check("single extra gnt", ng, 1);
        check("single credit after", credit_cnt, 0);

        // Round-robin with all requesting and credits returned one cycle after each send.
        do_reset();
        req    = 4'b1111;
        cur    = -1;
        len    = 0;
        idle   = 0;
        in_run = 1'b0;
        seen   = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            g = gnt;
            tick();
            if (g != '0) crd_toggle();
            if (g != '0) begin
                o = onehot_idx(g);
                if (in_run && o == cur) begin
                    len++;
                end else begin
                    if (in_run) begin
                        owners.push_back(cur);
                        lens.push_back(len);
                    end else if (seen) begin
                        gaps.push_back(idle);
                    end
                    cur    = o;
                    len    = 1;
                    in_run = 1'b1;
                    seen   = 1'b1;
                    idle   = 0;
                end
            end else begin
                if (in_run) begin
                    owners.push_back(cur);
                    lens.push_back(len);
                    in_run = 1'b0;
                end
                idle++;
            end
        end
        check("rr burst count ok", (owners.size() >= 5) ? 1 : 0, 1);
        check("rr gap count ok", (gaps.size() >= 4) ? 1 : 0, 1);
        for (int k = 0; k < 5; k++) begin
            if (k < owners.size()) begin
                check("rr owner", owners[k], k % NUM_REQ);
                check("rr burst length", lens[k], MAX_BURST);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (k < gaps.size()) check("rr idle gap", gaps[k], 1);
        end

        // Send and return on the same edge; then return at full credit.
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        tick();
        crd_toggle();
        @(negedge clk);
        check("simul pre credit_cnt", credit_cnt, 2);
        check("simul pre gnt", gnt, 4'b0001);
        tick();
        req = '0;
        @(negedge clk);
        check("simul credit_cnt", credit_cnt, 2);
        tick();
        crd_toggle();
        tick();
        crd_toggle();
        tick();
        @(negedge clk);
        check("refill credit_cnt", credit_cnt, 4);
        check("refill crd_err", crd_err, 0);
        tick();
        crd_toggle();
        tick();
        @(negedge clk);
        check("overflow credit_cnt", credit_cnt, 4);
        check("overflow crd_err", crd_err, 1);
        for (int c = 0; c < 5; c++) tick();
        @(negedge clk);
        check("sticky crd_err", crd_err, 1);

        // Single-wire glitch on the credit pair is not a credit.
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        tick();
        req = '0;
        @(negedge clk);
        check("glitch pre credit_cnt", credit_cnt, 2);
        tick();
        crd_pair_p = ~crd_pair_p;
        tick();
        crd_pair_p = ~crd_pair_p;
        tick();
        @(negedge clk);
        check("glitch credit_cnt", credit_cnt, 2);
        tick();
        crd_toggle();
        tick();
        @(negedge clk);
        check("glitch then both credit_cnt", credit_cnt, 3);

        // Reset in the middle of a burst; arbitration restarts at index 0.
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        req = '0;
        tick();
        req = 4'b0100;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        req     = 4'b1111;
        @(negedge clk);
        check("midreset gnt", gnt, 0);
        check("midreset busy", busy, 0);
        check("midreset diff_pair_p", diff_pair_p, 1);
        check("midreset diff_pair_n", diff_pair_n, 0);
        check("midreset credit_cnt", credit_cnt, 4);
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        check("restart owner", gnt, 4'b0001);

        // Randomized traffic, credit returns, glitches and occasional resets.
        do_reset();
        ret_pct = 30;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) ret_pct = int'($urandom_range(5, 60));
            tick();
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
            end
            r = int'($urandom_range(0, 99));
            if (r < ret_pct) crd_toggle();
            else if (r < ret_pct + 3) crd_pair_p = ~crd_pair_p;
            else if (r < ret_pct + 6) crd_pair_n = ~crd_pair_n;
        end

        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
